// File: rtl/seg7_pkg.sv
// seg7_pkg: segment bit order, glyph table and nibble-to-glyph decode
package seg7_pkg;
  localparam int SEG_A = 0;
  localparam int SEG_G = 6;
  localparam logic [6:0] GLYPH_DASH = 7'(1 << SEG_G);
  localparam logic [6:0] GLYPHS [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  function automatic logic [6:0] glyph_decode(input logic [3:0] nib, input logic hex);
    return (nib > 4'd9 && !hex) ? GLYPH_DASH : GLYPHS[nib];
  endfunction
endpackage

// File: rtl/seg7_glyph.sv
// seg7_glyph: active-high {G..A} pattern for one nibble
module seg7_glyph
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       hex,
  output logic [6:0] seg
);
  assign seg = glyph_decode(nib, hex);
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed N-digit 7-segment driver with tear-free loads and PWM
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int DWELL_CYCLES   = 3000,
  parameter int GAP_CYCLES     = 64,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [4*DIGITS-1:0]   load_value,
  input  logic [DIGITS-1:0]     load_dp,
  input  logic [DIGITS-1:0]     load_blank,
  input  logic                  load_hex,
  input  logic [2:0]            brightness,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     dig,
  output logic                  frame_done
);
  localparam int CW = DWELL_CYCLES > 1 ? $clog2(DWELL_CYCLES) : 1;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam int PW = $clog2(8 * DWELL_CYCLES) + 1;
  localparam logic SP = 1'(SEG_ACTIVE_LOW);
  localparam logic DP = 1'(DIG_ACTIVE_LOW);
  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;
  logic [4*DIGITS-1:0] sh_val, d_val;
  logic [DIGITS-1:0]   sh_dp, sh_blank, d_dp, d_blank;
  logic                sh_hex, d_hex, pending;
  logic [2:0]          bri;
  logic                last_cnt, boundary, lit;
  logic [PW-1:0]       lim, ofs;
  logic [3:0]          nib;
  logic [6:0]          glyph, seg_on;
  assign load_ready = !pending;
  assign last_cnt   = cnt == CW'(DWELL_CYCLES - 1);
  assign boundary   = last_cnt && idx == IW'(DIGITS - 1);
  assign nib        = d_val[{idx, 2'b00} +: 4];
  seg7_glyph u_glyph (.nib(nib), .hex(d_hex), .seg(glyph));
  // PWM window: lit after the anti-ghost gap for (bri+1)/8 of the remaining slot
  always_comb begin
    lim    = ((PW'(bri) + PW'(1)) * PW'(DWELL_CYCLES - GAP_CYCLES)) >> 3;
    ofs    = PW'(cnt) - PW'(GAP_CYCLES);
    lit    = cnt >= CW'(GAP_CYCLES) && ofs < lim;
    seg_on = d_blank[idx] ? 7'h00 : glyph;
  end
  // scan counters, load handshake, frame-synchronous display/brightness update, pin registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      idx        <= '0;
      pending    <= 1'b0;
      sh_val     <= '0;
      sh_dp      <= '0;
      sh_blank   <= '1;
      sh_hex     <= 1'b0;
      d_val      <= '0;
      d_dp       <= '0;
      d_blank    <= '1;
      d_hex      <= 1'b0;
      bri        <= 3'd7;
      seg        <= {7{SP}};
      dp         <= SP;
      dig        <= {DIGITS{DP}};
      frame_done <= 1'b0;
    end else begin
      cnt <= last_cnt ? '0 : cnt + 1'b1;
      if (last_cnt) idx <= idx == IW'(DIGITS - 1) ? '0 : idx + 1'b1;
      if (load_valid && !pending) begin
        sh_val   <= load_value;
        sh_dp    <= load_dp;
        sh_blank <= load_blank;
        sh_hex   <= load_hex;
        pending  <= 1'b1;
      end
      if (boundary) begin
        bri <= brightness;
        if (pending) begin
          d_val   <= sh_val;
          d_dp    <= sh_dp;
          d_blank <= sh_blank;
          d_hex   <= sh_hex;
          pending <= 1'b0;
        end
      end
      seg        <= seg_on ^ {7{SP}};
      dp         <= (!d_blank[idx] && d_dp[idx]) ^ SP;
      dig        <= (lit ? DIGITS'(1) << idx : '0) ^ {DIGITS{DP}};
      frame_done <= boundary;
    end
  end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed checks of scan timing, glyphs, PWM, handshake and reset
module tb_seg7_scan_driver;
  logic        clk = 0, rst_n = 0, load_valid = 0, load_hex = 0;
  logic [15:0] load_value = '0;
  logic [3:0]  load_dp = '0, load_blank = '0;
  logic [2:0]  brightness = 3'd7;
  logic        load_ready, dp, frame_done;
  logic [6:0]  seg;
  logic [3:0]  dig;
  int          tests = 0, fails = 0;
  int          on_cnt [4];
  logic [6:0]  sg [4];
  logic        dpv [4];
  int          multi, unblank, d3_lit, wait_n, stall;

  seg7_scan_driver #(.DIGITS(4), .DWELL_CYCLES(16), .GAP_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
    .load_value(load_value), .load_dp(load_dp), .load_blank(load_blank),
    .load_hex(load_hex), .brightness(brightness), .seg(seg), .dp(dp),
    .dig(dig), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_frame(input string tag);
    wait_n = 0; unblank = 0; d3_lit = 0;
    do begin
      @(negedge clk);
      wait_n++;
      if (seg !== 7'h7F) unblank++;
      if (dig[3] === 1'b0) d3_lit++;
    end while (frame_done !== 1'b1 && wait_n < 200);
    check({tag, "_fd"}, frame_done, 1);
  endtask

  task automatic capture();
    multi = 0; unblank = 0;
    for (int d = 0; d < 4; d++) begin on_cnt[d] = 0; sg[d] = 7'h55; dpv[d] = 1'bx; end
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (seg !== 7'h7F) unblank++;
      if ($countones(~dig) > 1) multi++;
      for (int d = 0; d < 4; d++)
        if (dig[d] === 1'b0) begin on_cnt[d]++; sg[d] = seg; dpv[d] = dp; end
    end
  endtask

  task automatic measure(input string tag);
    if (frame_done !== 1'b1) wait_frame(tag);
    capture();
  endtask

  task automatic do_load(input logic [15:0] v, input logic h, input logic [3:0] p, input logic [3:0] b);
    check("ready_before_load", load_ready, 1);
    load_value = v; load_hex = h; load_dp = p; load_blank = b; load_valid = 1;
    @(posedge clk);
    @(negedge clk);
    load_valid = 0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_dig", dig, 4'hF);
    check("rst_seg", seg, 7'h7F);
    check("rst_dp", dp, 1);
    check("rst_ready", load_ready, 1);
    check("rst_fd", frame_done, 0);
    rst_n = 1;
    wait_frame("first");
    check("first_frame_len", wait_n, 64);
    check("first_blank", unblank, 0);
    capture();
    check("period_fd", frame_done, 1);
    check("blank_seg", unblank, 0);
    check("blank_on0", on_cnt[0], 14);
    check("blank_on3", on_cnt[3], 14);
    check("onehot", multi, 0);
    // hex load mid-frame
    repeat (20) @(negedge clk);
    do_load(16'h3A10, 1, 4'b0000, 4'b0000);
    check("pending_ready", load_ready, 0);
    wait_frame("old");
    check("old_frame_blank", unblank, 0);
    capture();
    check("hex_d0", sg[0], 7'h40);
    check("hex_d1", sg[1], 7'h79);
    check("hex_d2", sg[2], 7'h08);
    check("hex_d3", sg[3], 7'h30);
    check("hex_dp0", dpv[0], 1);
    for (int d = 0; d < 4; d++) check($sformatf("hex_on%0d", d), on_cnt[d], 14);
    // decimal mode with one decimal point
    repeat (10) @(negedge clk);
    do_load(16'h3A10, 0, 4'b0010, 4'b0000);
    measure("dec");
    check("dec_d2_dash", sg[2], 7'h3F);
    check("dec_d0", sg[0], 7'h40);
    check("dec_dp1", dpv[1], 0);
    check("dec_dp0", dpv[0], 1);
    // brightness change mid-frame is deferred to the boundary
    repeat (10) @(negedge clk);
    brightness = 3'd0;
    wait_frame("bri");
    check("bri_deferred", d3_lit, 14);
    capture();
    for (int d = 0; d < 4; d++) check($sformatf("bri0_on%0d", d), on_cnt[d], 1);
    brightness = 3'd7;
    // back-to-back loads: second stalls until the boundary
    repeat (5) @(negedge clk);
    do_load(16'h1111, 1, 4'b0000, 4'b0000);
    check("b2b_ready_low", load_ready, 0);
    load_value = 16'h8888; load_valid = 1; stall = 0;
    while (load_ready !== 1'b1 && stall < 200) begin stall++; @(negedge clk); end
    check("b2b_stall", stall, 58);
    check("ready_recovery_fd", frame_done, 1);
    @(posedge clk);
    #1 load_valid = 0;
    capture();
    check("b2b_first", sg[0], 7'h79);
    measure("pair2");
    check("b2b_second_d0", sg[0], 7'h00);
    check("b2b_second_d3", sg[3], 7'h00);
    // load accepted on the boundary cycle applies one frame later
    repeat (63) @(negedge clk);
    do_load(16'h1F03, 1, 4'b0000, 4'b0000);
    check("bnd_align", frame_done, 1);
    check("bnd_pending", load_ready, 0);
    capture();
    check("bnd_not_yet", sg[0], 7'h00);
    measure("bnd");
    check("bnd_d0", sg[0], 7'h30);
    check("bnd_d2", sg[2], 7'h0E);
    check("bnd_d3", sg[3], 7'h79);
    // reset mid-slot with a load pending
    repeat (20) @(negedge clk);
    do_load(16'h2222, 1, 4'b0000, 4'b0000);
    check("rst2_pending", load_ready, 0);
    repeat (3) @(negedge clk);
    rst_n = 0;
    #1;
    check("rst2_dig", dig, 4'hF);
    check("rst2_seg", seg, 7'h7F);
    check("rst2_ready", load_ready, 1);
    check("rst2_fd", frame_done, 0);
    @(negedge clk);
    rst_n = 1;
    wait_frame("post_rst");
    check("post_rst_len", wait_n, 64);
    check("post_rst_blank", unblank, 0);
    capture();
    check("no_stale_apply", unblank, 0);
    check("post_rst_on1", on_cnt[1], 14);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Parametrised, time-multiplexed seven-segment display driver for the FPGA demo tops. It replaces the single-digit combinational decoder and drives N common-anode/cathode digits from one segment bus. Features: frame-synchronous (tear-free) value updates with a valid/ready load port, decimal/hex mode, per-digit blank and decimal point, anti-ghosting gap, and 8-level PWM brightness. It sits between the classifier result logic and the PMOD pins.

## Interface
- DIGITS, 4: number of digits scanned, 1..8
- DWELL_CYCLES, 3000: clocks per digit slot (12 MHz / 3000 = 4 kHz slot rate)
- GAP_CYCLES, 64: all-digits-off cycles at start of each slot; must be < DWELL_CYCLES
- SEG_ACTIVE_LOW, 1: 1 = seg/dp pins are low-active
- DIG_ACTIVE_LOW, 1: 1 = dig pins are low-active
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- load_valid  in  1  new display contents offered
- load_ready  out  1  driver can accept a load
- load_value  in  4*DIGITS  nibble per digit; digit 0 = [3:0]
- load_dp  in  DIGITS  decimal point per digit
- load_blank  in  DIGITS  1 = digit dark
- load_hex  in  1  1 = hex glyphs, 0 = decimal glyphs
- brightness  in  3  duty level 0..7 (duty = (b+1)/8)
- seg  out  7  segments {G,F,E,D,C,B,A}
- dp  out  1  decimal point
- dig  out  DIGITS  digit enables, one-hot or none
- frame_done  out  1  one-cycle pulse at end of each full scan

## Operation
- Counters: cnt 0..DWELL_CYCLES-1, idx 0..DIGITS-1; cnt wraps each slot, idx advances on cnt wrap and wraps after DIGITS-1.
- Frame boundary: cycle with cnt==DWELL_CYCLES-1 and idx==DIGITS-1; frame_done pulses there.
- Load handshake: transfer when load_valid && load_ready. Captures value/dp/blank/hex into shadow registers and sets pending. load_ready = !pending.
- At frame boundary, if pending: display <= shadow, pending <= 0. The current frame always completes with the old contents.
- A load accepted on the frame-boundary cycle itself is not applied until the next boundary.
- brightness is sampled into a register only at frame boundaries.
- Slot lighting: dig[idx] active iff cnt >= GAP_CYCLES and (cnt-GAP_CYCLES) < ((bri+1)*(DWELL_CYCLES-GAP_CYCLES))>>3. Product width must hold 8*DWELL_CYCLES without overflow. All other dig bits are always inactive.
- Glyphs: 0-9 standard. Hex mode: A b C d E F. Decimal mode: 10-15 show "-" (G only). Blanked digit: seg and dp inactive, dig still cycles normally.
- Codes (active-high, GFEDCBA): 0=0111111, 1=0000110, 3=1001111, 8=1111111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001, "-"=1000000.
- Polarity parameters invert only at the pins.

## Timing
- All outputs are registered. Pins reflect the internal cnt/idx/display state with 1-cycle latency.
- Reset (async, immediate): cnt=0, idx=0, pending=0, display all blanked, bri=7, load_ready=1, frame_done=0, seg/dp/dig all inactive at pin polarity (e.g. seg=7'h7F, dig=4'hF for defaults).
- Reset mid-scan or with a load pending discards the shadow. The first frame after reset starts at idx 0, cnt 0.
- Frame period = DIGITS*DWELL_CYCLES cycles exactly, independent of loads.
- Worst-case load-to-display latency ≈ 2 frames. Load-ready recovery is 1 cycle after the boundary.

## Structure
- Package seg7_pkg: glyph constants, segment bit-order definition, and glyph decode function (nibble, hex) -> 7 bits.
- One sub-module, seg7_glyph: combinational decode wrapping the package function. The scan FSM, counters, handshake and PWM stay in the top module.

## Test plan
Bench: DIGITS=4, DWELL=16, GAP=2, defaults otherwise.
- Reset, then observe: dig=4'hF, seg=7'h7F, load_ready=1, frame_done pulses every 64 cycles.
- Load 0x3A10, hex=1, brightness=7 mid-frame: old (blank) frame finishes; next frame shows digit0 seg=~0111111, digit1 ~0000110, digit2 ~1110111, digit3 ~1001111. Each dig is low for 14 of 16 cycles.
- Same value, hex=0: digit2 shows ~1000000 ("-").
- brightness=0: each dig is low for exactly 1 cycle per slot (14*1>>3). Change brightness mid-frame: takes effect only at the next boundary.
- Two back-to-back loads: the second is stalled (load_ready=0) until the boundary. Load on the boundary cycle: applied one frame later.
- Assert rst_n low mid-slot with a load pending: outputs go inactive immediately. After release the display is blank and no pending update is applied.
